// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_wb_arbiter                                              |
// | Purpose  : Shares the register-file write port between the ALU (req0) and |
// |            load (req1) writeback paths. Each path has a one-entry holding  |
// |            slot. An age-aware round-robin arbiter drains the slots into    |
// |            registered write-port outputs. A pending-write mask is exported |
// |            for read-after-write hazard stalls.                             |
// | Options  : `define REGFILE_WB_ARB_STATS_EN adds conflict_cnt and           |
// |            zero_drop_cnt statistics outputs.                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_reg,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_reg,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 rf_reg_write,
  output logic                 rf_reg_dst,
  output logic [ADDR_W-1:0]    rf_write_reg,
  output logic [DATA_W-1:0]    rf_write_data,
  output logic [2**ADDR_W-1:0] pending_mask
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  output logic [15:0]          conflict_cnt,
  output logic [7:0]           zero_drop_cnt
`endif
);

  localparam logic [ADDR_W-1:0] c_ZERO_REG = '0;

  // Holding slots
  logic              slot0_valid_q, slot0_valid_d;
  logic [ADDR_W-1:0] slot0_reg_q,   slot0_reg_d;
  logic [DATA_W-1:0] slot0_data_q,  slot0_data_d;
  logic              slot1_valid_q, slot1_valid_d;
  logic [ADDR_W-1:0] slot1_reg_q,   slot1_reg_d;
  logic [DATA_W-1:0] slot1_data_q,  slot1_data_d;

  // Set when slot1 holds the older entry of two occupants
  logic              age1_older_q,  age1_older_d;
  // Round-robin pointer: requester preferred on the next contended grant
  logic              rr_ptr_q,      rr_ptr_d;

  // Registered write port
  logic              wr_q,          wr_d;
  logic [ADDR_W-1:0] wreg_q,        wreg_d;
  logic [DATA_W-1:0] wdata_q,       wdata_d;

  // Combinational arbitration and handshake terms
  logic w_both;
  logic w_same_reg;
  logic w_grant0;
  logic w_grant1;
  logic w_rr_toggle;
  logic w_xfer0;
  logic w_xfer1;
  logic w_cap0;
  logic w_cap1;
  logic w_drop0;
  logic w_drop1;
  logic w_stay0;
  logic w_stay1;

  // Arbitration over the currently occupied slots (registered state only)
  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_rr_toggle = 1'b0;
    w_both      = slot0_valid_q && slot1_valid_q;
    w_same_reg  = (slot0_reg_q == slot1_reg_q);
    if (w_both) begin
      if (w_same_reg) begin
        // Same destination: commit in capture order
        w_grant1 = age1_older_q;
        w_grant0 = !age1_older_q;
      end else begin
        w_grant1    = rr_ptr_q;
        w_grant0    = !rr_ptr_q;
        w_rr_toggle = 1'b1;
      end
    end else begin
      w_grant0 = slot0_valid_q;
      w_grant1 = slot1_valid_q;
    end
  end

  // Ready depends only on registered state, never on valid
  assign req0_ready = !slot0_valid_q || w_grant0;
  assign req1_ready = !slot1_valid_q || w_grant1;

  // Transfer classification: $zero writes are accepted but discarded
  assign w_xfer0 = req0_valid && req0_ready;
  assign w_xfer1 = req1_valid && req1_ready;
  assign w_cap0  = w_xfer0 && (req0_reg != c_ZERO_REG);
  assign w_cap1  = w_xfer1 && (req1_reg != c_ZERO_REG);
  assign w_drop0 = w_xfer0 && (req0_reg == c_ZERO_REG);
  assign w_drop1 = w_xfer1 && (req1_reg == c_ZERO_REG);

  // An old entry survives the edge when it is held and not granted
  assign w_stay0 = slot0_valid_q && !w_grant0;
  assign w_stay1 = slot1_valid_q && !w_grant1;

  // Slot next-state: capture wins over grant so refill-and-drain has no bubble
  always_comb begin
    slot0_valid_d = slot0_valid_q;
    slot0_reg_d   = slot0_reg_q;
    slot0_data_d  = slot0_data_q;
    slot1_valid_d = slot1_valid_q;
    slot1_reg_d   = slot1_reg_q;
    slot1_data_d  = slot1_data_q;
    if (w_grant0) begin
      slot0_valid_d = 1'b0;
    end
    if (w_cap0) begin
      slot0_valid_d = 1'b1;
      slot0_reg_d   = req0_reg;
      slot0_data_d  = req0_data;
    end
    if (w_grant1) begin
      slot1_valid_d = 1'b0;
    end
    if (w_cap1) begin
      slot1_valid_d = 1'b1;
      slot1_reg_d   = req1_reg;
      slot1_data_d  = req1_data;
    end
  end

  // Age and round-robin next-state
  always_comb begin
    age1_older_d = age1_older_q;
    rr_ptr_d     = rr_ptr_q;
    // slot1 is older only if slot0 alone is refilled while slot1 keeps its
    // entry; a simultaneous capture makes slot0 the older one
    if (w_cap0 || w_cap1) begin
      age1_older_d = w_cap0 && !w_cap1 && w_stay1;
    end
    if (w_rr_toggle) begin
      rr_ptr_d = !rr_ptr_q;
    end
  end

  // Write-port next-state: strobe on grant, hold index/data otherwise
  always_comb begin
    wr_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (w_grant0) begin
      wr_d    = 1'b1;
      wreg_d  = slot0_reg_q;
      wdata_d = slot0_data_q;
    end else if (w_grant1) begin
      wr_d    = 1'b1;
      wreg_d  = slot1_reg_q;
      wdata_d = slot1_data_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_valid_q <= 1'b0;
      slot0_reg_q   <= '0;
      slot0_data_q  <= '0;
      slot1_valid_q <= 1'b0;
      slot1_reg_q   <= '0;
      slot1_data_q  <= '0;
      age1_older_q  <= 1'b0;
      rr_ptr_q      <= 1'b0;
      wr_q          <= 1'b0;
      wreg_q        <= '0;
      wdata_q       <= '0;
    end else begin
      slot0_valid_q <= slot0_valid_d;
      slot0_reg_q   <= slot0_reg_d;
      slot0_data_q  <= slot0_data_d;
      slot1_valid_q <= slot1_valid_d;
      slot1_reg_q   <= slot1_reg_d;
      slot1_data_q  <= slot1_data_d;
      age1_older_q  <= age1_older_d;
      rr_ptr_q      <= rr_ptr_d;
      wr_q          <= wr_d;
      wreg_q        <= wreg_d;
      wdata_q       <= wdata_d;
    end
  end

  assign rf_reg_write  = wr_q;
  assign rf_reg_dst    = 1'b1;
  assign rf_write_reg  = wreg_q;
  assign rf_write_data = wdata_q;

  // Pending-write mask: held slots plus the write being driven; $zero never pends
  always_comb begin
    pending_mask = '0;
    if (slot0_valid_q) begin
      pending_mask[slot0_reg_q] = 1'b1;
    end
    if (slot1_valid_q) begin
      pending_mask[slot1_reg_q] = 1'b1;
    end
    if (wr_q) begin
      pending_mask[wreg_q] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [15:0] conflict_cnt_q,  conflict_cnt_d;
  logic [7:0]  zero_drop_cnt_q, zero_drop_cnt_d;
  logic [8:0]  w_drop_sum;

  // Saturating statistics counters
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (w_both && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
    w_drop_sum = {1'b0, zero_drop_cnt_q} + {8'd0, w_drop0} + {8'd0, w_drop1};
    zero_drop_cnt_d = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q  <= '0;
      zero_drop_cnt_q <= '0;
    end else begin
      conflict_cnt_q  <= conflict_cnt_d;
      zero_drop_cnt_q <= zero_drop_cnt_d;
    end
  end

  assign conflict_cnt  = conflict_cnt_q;
  assign zero_drop_cnt = zero_drop_cnt_q;
`endif

endmodule
`default_nettype wire
